scaler_h_ctrl: RTL and testbench

Controller for the horizontal linear scaler. It monitors the scaler's input video stream to measure the active line width. From that width and a configured output width it computes the (4.12) step as in_width*PIXEL_STEP/out_width, using a sequential restoring divider. The new step is applied atomically at the next frame start, so `scale_step_h` never changes mid-frame.

---
 rtl/scaler_pkg.sv | 9 +
 rtl/seq_div_u.sv | 37 +++
 rtl/scaler_h_ctrl.sv | 75 +++++++
 tb/tb_scaler_h_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants and controller state encoding for the horizontal scaler
package scaler_pkg;
  localparam int PIXEL_STEP = 4096;
  localparam int FRAC_BITS = $clog2(PIXEL_STEP);
  localparam int STEP_WIDTH = 16;
  localparam int WIDTH_BITS = 13;
  localparam int DEFAULT_STEP = 4096;
  typedef enum logic [1:0] {IDLE, DIV, PEND} state_t;
endpackage

// File: rtl/seq_div_u.sv
// seq_div_u: unsigned restoring divider, one quotient bit per cycle, NW cycles after start
// done is high during the final iteration; quotient holds the result from the next cycle on
module seq_div_u #(
  parameter int NW = 25,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [NW-1:0] quotient
);
  localparam int CW = $clog2(NW + 1);
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW:0] sh, diff;
  assign sh = {rem, quotient[NW-1]};
  assign diff = sh - {1'b0, divisor};
  assign done = cnt == CW'(1);
  // diff MSB set means the trial subtraction went negative: restore
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rem <= '0;
      quotient <= '0;
    end else if (start) begin
      cnt <= CW'(NW);
      rem <= '0;
      quotient <= dividend;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= diff[DW] ? sh[DW-1:0] : diff[DW-1:0];
      quotient <= {quotient[NW-2:0], ~diff[DW]};
    end
endmodule

// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl: measures the active line width and computes the horizontal scale step,
// applying each new step only at a frame start
module scaler_h_ctrl
  import scaler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH_BITS-1:0] cfg_out_width,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step_h,
  output logic [WIDTH_BITS-1:0] in_width,
  output logic                  busy,
  output logic                  err_o
);
  localparam int NW = WIDTH_BITS + FRAC_BITS;
  localparam logic [WIDTH_BITS-1:0] W_MAX = '1;
  localparam logic [STEP_WIDTH-1:0] S_MAX = '1;
  state_t state, next;
  logic [WIDTH_BITS-1:0] px_cnt, line_w, out_w, meas_w, div_w, div_d;
  logic [NW-1:0] quo;
  logic hsf, fb, cfg_acc, auto_trig, start, done, sat;
  assign hsf = de_i && hs_i;
  assign fb = de_i && vs_i;
  // width of the line that just ended, including the one closing at this very edge
  assign meas_w = (hsf && px_cnt != '0) ? px_cnt : line_w;
  assign cfg_ready = state == IDLE;
  assign busy = !cfg_ready;
  assign cfg_acc = cfg_valid && cfg_ready;
  assign auto_trig = fb && meas_w != '0 && meas_w != in_width && out_w != '0;
  assign div_w = (fb && meas_w != '0) ? meas_w : in_width;
  assign div_d = cfg_acc ? cfg_out_width : out_w;
  assign start = cfg_ready && (cfg_acc || auto_trig) && div_w != '0 && div_d != '0;
  assign sat = |quo[NW-1:STEP_WIDTH];
  seq_div_u #(.NW(NW), .DW(WIDTH_BITS)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend({div_w, {FRAC_BITS{1'b0}}}),
    .divisor(div_d),
    .done(done),
    .quotient(quo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = (state == IDLE && start) ? DIV :
           (state == DIV && done) ? PEND :
           (state == PEND && fb) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      px_cnt <= '0;
      line_w <= '0;
      in_width <= '0;
      out_w <= '0;
      err_o <= 1'b0;
      scale_step_h <= STEP_WIDTH'(DEFAULT_STEP);
    end else begin
      if (de_i) px_cnt <= hsf ? WIDTH_BITS'(1) : (px_cnt == W_MAX ? px_cnt : px_cnt + WIDTH_BITS'(1));
      if (hsf && px_cnt != '0) line_w <= px_cnt;
      if (fb && meas_w != '0) in_width <= meas_w;
      if (cfg_acc) begin
        out_w <= cfg_out_width;
        err_o <= cfg_out_width == '0;
      end
      if (state == PEND && sat) err_o <= 1'b1;
      if (state == PEND && fb) scale_step_h <= sat ? S_MAX : quo[STEP_WIDTH-1:0];
    end
endmodule

// File: tb/tb_scaler_h_ctrl.sv
// tb_scaler_h_ctrl: directed bench for scaler_h_ctrl; expected steps are queued when
// stimulus is issued and popped whenever the DUT's step output changes
module tb_scaler_h_ctrl;
  logic clk = 0, rst_n = 0, cfg_valid = 0, cfg_ready, de_i = 0, hs_i = 0, vs_i = 0, busy, err_o;
  logic [12:0] cfg_out_width = '0, in_width;
  logic [15:0] scale_step_h, prev_step = 16'd4096;
  int total = 0, passed = 0, line_px = 1920, tmo;
  bit video_on = 0, fb_at_edge = 0, hold_bad;
  int sb[$];

  always #5 clk = ~clk;

  scaler_h_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_out_width(cfg_out_width),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .de_i(de_i),
    .hs_i(hs_i),
    .vs_i(vs_i),
    .scale_step_h(scale_step_h),
    .in_width(in_width),
    .busy(busy),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_fb(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!fb_at_edge && c < 20000);
      if (!fb_at_edge) chk("fb_timeout", c, 0);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic send_cfg(input int w);
    int c;
    c = 0;
    cfg_out_width = 13'(w);
    cfg_valid = 1;
    while (!cfg_ready && c < 20000) begin
      @(negedge clk);
      c++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", c, 0);
    @(posedge clk);
    #1 cfg_valid = 0;
  endtask

  // video source: 2 lines per frame, 8 blanking cycles per line; width read at frame start
  initial begin
    int w;
    wait (video_on);
    forever begin
      w = line_px;
      for (int l = 0; l < 2; l++) begin
        for (int p = 0; p < w; p++) begin
          @(posedge clk);
          #1;
          de_i = 1;
          hs_i = (p == 0);
          vs_i = (p == 0 && l == 0);
        end
        for (int b = 0; b < 8; b++) begin
          @(posedge clk);
          #1;
          de_i = 0;
          hs_i = 0;
          vs_i = 0;
        end
      end
    end
  end

  always @(posedge clk) fb_at_edge <= de_i && vs_i;

  // every step change must be the cycle after a frame boundary and match the next queued value
  always @(negedge clk)
    if (!rst_n) prev_step <= scale_step_h;
    else if (scale_step_h !== prev_step) begin
      chk("step_on_fb_edge", int'(fb_at_edge), 1);
      if (sb.size() == 0) chk("unexpected_step", int'(scale_step_h), int'(prev_step));
      else chk("step", int'(scale_step_h), sb.pop_front());
      prev_step <= scale_step_h;
    end

  initial begin
    #23;
    chk("rst_step", scale_step_h, 4096);
    chk("rst_in_width", in_width, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1;
    video_on = 1;
    // no cfg: width is measured but the step stays at its default
    wait_fb(3);
    chk("t1_in_width", in_width, 1920);
    chk("t1_step", scale_step_h, 4096);
    chk("t1_busy", busy, 0);
    chk("t1_err", err_o, 0);
    // mid-frame cfg 960 -> 8192, held until the next frame boundary
    repeat (500) @(negedge clk);
    send_cfg(960);
    sb.push_back(8192);
    @(negedge clk);
    chk("t2_busy", busy, 1);
    chk("t2_cfg_ready", cfg_ready, 0);
    chk("t2_step_held", scale_step_h, 4096);
    drain();
    chk("t2_busy_after", busy, 0);
    // switch to 960 px: auto recalc 960/960 -> 4096, then cfg 1920 -> 2048
    line_px = 960;
    sb.push_back(4096);
    drain();
    chk("t3_in_width_960", in_width, 960);
    send_cfg(1920);
    sb.push_back(2048);
    drain();
    // back to 1920 px with out_w 1920: auto trigger, applied one frame later
    line_px = 1920;
    wait_fb(2);
    chk("t3_auto_busy", busy, 1);
    chk("t3_auto_step_held", scale_step_h, 2048);
    sb.push_back(4096);
    drain();
    chk("t3_in_width_1920", in_width, 1920);
    // saturation, then recovery
    send_cfg(100);
    sb.push_back(65535);
    drain();
    chk("t4_sat_err", err_o, 1);
    chk("t4_sat_step", scale_step_h, 65535);
    send_cfg(1280);
    chk("t4_err_cleared", err_o, 0);
    sb.push_back(6144);
    drain();
    chk("t4_err_after", err_o, 0);
    // cfg held off while busy, then cfg 0 accepted on the first idle cycle
    send_cfg(960);
    sb.push_back(8192);
    cfg_out_width = 0;
    cfg_valid = 1;
    hold_bad = 0;
    tmo = 0;
    while (busy && tmo < 20000) begin
      if (cfg_ready !== 1'b0) hold_bad = 1;
      @(negedge clk);
      tmo++;
    end
    chk("t5_ready_low_while_busy", int'(hold_bad), 0);
    chk("t5_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 0;
    chk("t5_zero_err", err_o, 1);
    chk("t5_zero_busy", busy, 0);
    chk("t5_step_kept", scale_step_h, 8192);
    // reset in the middle of a division discards it
    send_cfg(640);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_step", scale_step_h, 4096);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_in_width", in_width, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1;
    wait_fb(3);
    chk("t6_step_after", scale_step_h, 4096);
    chk("t6_busy_after", busy, 0);
    chk("t6_in_width_after", in_width, 1920);
    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
